// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the sequencer's control handshakes and strobes so that the
// controller and its environment connect through a single port.
//   slave  : the sequencer side (takes start/instr/acks, drives strobes)
//   master : the environment side (PC, IR, instruction memory, execute unit)
// Signals:
//   start, instr[7:0], imem_ack, zero_flag, exec_done       -> sequencer
//   imem_req, pc_en_direct_read, pc_inc, pc_en_write,
//   tgt_sel, ir_load, exec_start, halted, retired[15:0]      <- sequencer
interface pc_sequencer_if;
    logic        start;
    logic [7:0]  instr;
    logic        imem_ack;
    logic        zero_flag;
    logic        exec_done;
    logic        imem_req;
    logic        pc_en_direct_read;
    logic        pc_inc;
    logic        pc_en_write;
    logic        tgt_sel;
    logic        ir_load;
    logic        exec_start;
    logic        halted;
    logic [15:0] retired;

    modport master (
        output start, instr, imem_ack, zero_flag, exec_done,
        input  imem_req, pc_en_direct_read, pc_inc, pc_en_write,
               tgt_sel, ir_load, exec_start, halted, retired
    );

    modport slave (
        input  start, instr, imem_ack, zero_flag, exec_done,
        output imem_req, pc_en_direct_read, pc_inc, pc_en_write,
               tgt_sel, ir_load, exec_start, halted, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch/execute controller owning the sequencing of the program counter.
// It fetches an instruction byte over a req/ack handshake, latches it into
// the IR while incrementing the PC, decodes the opcode, and then either
// starts the execute unit, loads the PC with a jump target, or halts.
// Ports:
//   clk   - system clock, all state changes on posedge
//   reset - synchronous, active-high; returns to IDLE with all strobes low
//   bus   - pc_sequencer_if.slave (start/instr/handshakes in, strobes out,
//           retired-instruction counter out)
// Every output is a register loaded together with the state, so each strobe
// is high for whole cycles and the negedge-clocked PC samples it once.
module pc_sequencer #(
    parameter int unsigned         ADDR_W   = 10,
    parameter int unsigned         OPC_W    = 4,
    parameter logic [OPC_W-1:0]    OPC_JMP  = 4'hE,
    parameter logic [OPC_W-1:0]    OPC_JMPZ = 4'hD,
    parameter logic [OPC_W-1:0]    OPC_HALT = 4'hF
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    // The opcode occupies the top OPC_W bits of the byte; the PC width only
    // matters to the PC itself, but must be sane for the system to exist.
    if (ADDR_W < 1 || OPC_W < 1 || OPC_W > 7) begin : g_bad_params
        $error("pc_sequencer: unsupported ADDR_W/OPC_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        DECODE,
        EXEC,
        JUMP,
        HALTED
    } state_t;

    state_t           state;
    logic [OPC_W-1:0] opc_q;
    logic             imem_req_q;
    logic             pc_en_direct_read_q;
    logic             pc_inc_q;
    logic             pc_en_write_q;
    logic             tgt_sel_q;
    logic             ir_load_q;
    logic             exec_start_q;
    logic             halted_q;
    logic [15:0]      retired_q;

    // Operand bits belong to the datapath; only the opcode is decoded here.
    logic unused_operand;
    assign unused_operand = ^bus.instr[7-OPC_W:0];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            opc_q               <= '0;
            imem_req_q          <= 1'b0;
            pc_en_direct_read_q <= 1'b0;
            pc_inc_q            <= 1'b0;
            pc_en_write_q       <= 1'b0;
            tgt_sel_q           <= 1'b0;
            ir_load_q           <= 1'b0;
            exec_start_q        <= 1'b0;
            halted_q            <= 1'b0;
            retired_q           <= '0;
        end else begin
            // Strobes default low; each branch raises the ones belonging to
            // the state being entered.
            imem_req_q          <= 1'b0;
            pc_en_direct_read_q <= 1'b0;
            pc_inc_q            <= 1'b0;
            pc_en_write_q       <= 1'b0;
            tgt_sel_q           <= 1'b0;
            ir_load_q           <= 1'b0;
            exec_start_q        <= 1'b0;
            halted_q            <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state               <= FETCH;
                        imem_req_q          <= 1'b1;
                        pc_en_direct_read_q <= 1'b1;
                    end
                end

                FETCH: begin
                    if (bus.imem_ack) begin
                        state     <= LOAD;
                        opc_q     <= bus.instr[7 -: OPC_W];
                        ir_load_q <= 1'b1;
                        pc_inc_q  <= 1'b1;
                    end else begin
                        imem_req_q          <= 1'b1;
                        pc_en_direct_read_q <= 1'b1;
                    end
                end

                LOAD: begin
                    state <= DECODE;
                end

                DECODE: begin
                    if (opc_q == OPC_HALT) begin
                        state     <= HALTED;
                        halted_q  <= 1'b1;
                        retired_q <= sat_inc(retired_q);
                    end else if (opc_q == OPC_JMP ||
                                 (opc_q == OPC_JMPZ && bus.zero_flag)) begin
                        state         <= JUMP;
                        tgt_sel_q     <= 1'b1;
                        pc_en_write_q <= 1'b1;
                    end else if (opc_q == OPC_JMPZ) begin
                        // Not-taken branch: the LOAD increment already
                        // advanced the PC, so fetch straight away.
                        state               <= FETCH;
                        imem_req_q          <= 1'b1;
                        pc_en_direct_read_q <= 1'b1;
                        retired_q           <= sat_inc(retired_q);
                    end else begin
                        state        <= EXEC;
                        exec_start_q <= 1'b1;
                    end
                end

                EXEC: begin
                    // exec_done may already be high in the exec_start cycle.
                    if (bus.exec_done) begin
                        state               <= FETCH;
                        imem_req_q          <= 1'b1;
                        pc_en_direct_read_q <= 1'b1;
                        retired_q           <= sat_inc(retired_q);
                    end
                end

                JUMP: begin
                    state               <= FETCH;
                    imem_req_q          <= 1'b1;
                    pc_en_direct_read_q <= 1'b1;
                    retired_q           <= sat_inc(retired_q);
                end

                HALTED: begin
                    // Resume fetching from wherever the PC was left.
                    if (bus.start) begin
                        state               <= FETCH;
                        imem_req_q          <= 1'b1;
                        pc_en_direct_read_q <= 1'b1;
                    end else begin
                        halted_q <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req          = imem_req_q;
    assign bus.pc_en_direct_read = pc_en_direct_read_q;
    assign bus.pc_inc            = pc_inc_q;
    assign bus.pc_en_write       = pc_en_write_q;
    assign bus.tgt_sel           = tgt_sel_q;
    assign bus.ir_load           = ir_load_q;
    assign bus.exec_start        = exec_start_q;
    assign bus.halted            = halted_q;
    assign bus.retired           = retired_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute controller that owns the 10-bit program counter register and sequences every access to it. It issues PC strobes (direct read for instruction fetch, increment, load), runs the instruction-memory handshake, latches the instruction register, and hands each decoded instruction to the execute datapath. It also resolves jumps and halts. It sits between the top-level start/halt controls and the PC, IR and execute units of the down-sampling processor.

## Interface
Parameters:
- ADDR_W, 10, PC / jump-target width
- OPC_W, 4, opcode field width (instr[7:4])
- OPC_JMP, 4'hE, unconditional jump opcode
- OPC_JMPZ, 4'hD, jump-if-zero opcode
- OPC_HALT, 4'hF, halt opcode

Ports:
- clk  in  1  system clock; all controller state changes on posedge
- reset  in  1  synchronous, active-high
- start  in  1  level; leave IDLE/HALTED and begin fetching
- instr  in  8  instruction byte from instruction memory
- imem_ack  in  1  instruction memory data valid (may wait N≥0 cycles)
- zero_flag  in  1  ALU zero flag, sampled in DECODE
- exec_done  in  1  execute unit finished current instruction
- imem_req  out  1  fetch request, held until ack
- pc_en_direct_read  out  1  drive PC onto instruction-address bus
- pc_inc  out  1  PC increment strobe
- pc_en_write  out  1  PC load strobe (target on PC input bus)
- tgt_sel  out  1  1 = PC input bus sourced from jump-target operand
- ir_load  out  1  latch instr into IR
- exec_start  out  1  one-cycle pulse starting execute unit
- halted  out  1  high in HALTED
- retired  out  16  instructions completed, saturating at 16'hFFFF

## Operation
- States: IDLE, FETCH, LOAD, DECODE, EXEC, JUMP, HALTED. Reset → IDLE, all outputs 0, retired = 0.
- IDLE: start=1 → FETCH.
- FETCH: imem_req=1, pc_en_direct_read=1; stay until imem_ack=1, then → LOAD.
- LOAD: ir_load=1, pc_inc=1 (exactly one cycle); → DECODE. Opcode captured internally from instr at the FETCH→LOAD edge.
- DECODE: OPC_HALT → HALTED; OPC_JMP, or OPC_JMPZ with zero_flag=1 → JUMP; OPC_JMPZ with zero_flag=0 → FETCH (retire); otherwise → EXEC with exec_start pulsed in the first EXEC cycle.
- EXEC: wait for exec_done=1 → FETCH (retire). exec_done in the exec_start cycle is legal and accepted.
- JUMP: tgt_sel=1, pc_en_write=1 for one cycle; → FETCH (retire). Jump target is the operand the datapath places on the PC input bus; this block only selects it.
- HALTED: halted=1; HALT retires on entry. start=1 → FETCH (resume at current PC, no reset of PC).
- pc_inc and pc_en_write never both high. Jump replaces, not adds to, the LOAD increment.
- retired increments once per completed instruction (HALT, jump, not-taken JMPZ, EXEC exit); holds at 16'hFFFF.
- PC wrap 10'h3FF→10'h000 is the PC's concern; the controller takes no action.
- reset in any state (including mid-handshake with imem_req high) → IDLE next edge, all strobes low, retired cleared; a late imem_ack is ignored.

## Timing
- All outputs registered (Moore, decoded from state register); strobes change only on posedge.
- PC register updates on negedge clk; every PC strobe is high for a full cycle so the mid-cycle negedge samples it exactly once.
- Minimum instruction latency: non-jump ALU op with imem_ack and exec_done immediate = FETCH, LOAD, DECODE, EXEC = 4 cycles; jump = 4 cycles; not-taken JMPZ = 3 cycles.
- zero_flag sampled only on the DECODE→next edge; changes elsewhere are ignored.
- start is ignored outside IDLE/HALTED.

## Test plan
- Reset: assert reset 2 cycles mid-FETCH with imem_ack low → all outputs 0, state IDLE, retired=0; late imem_ack produces no ir_load.
- Straight-line: start, instr=8'h12, imem_ack and exec_done immediate → pc_inc high exactly 1 cycle per instruction, exec_start 1 cycle, 4 cycles per instruction, retired=3 after 3 instructions.
- Memory wait: imem_ack delayed 5 cycles → imem_req and pc_en_direct_read held 6 cycles, no pc_inc until LOAD.
- Jumps: instr=8'hE0 → pc_en_write and tgt_sel 1 cycle, no exec_start; instr=8'hD0 with zero_flag=0 → no pc_en_write, back to FETCH after 3 cycles; zero_flag=1 → jump taken.
- Halt/resume: instr=8'hF0 → halted=1, no further imem_req; start pulse → FETCH, halted=0, retired continues from prior value.
- Saturation: preload path via 65535 instructions (or force) → retired stays 16'hFFFF after further instructions.
